// File: rtl/p4_router_egress_pkg.sv
// Shared types and helpers for the egress port demux.
// Holds FSM state enum, sideband widths, dest check.
package p4_router_egress_pkg;

  localparam int DEST_WIDTH_DFLT = 4;
  localparam int USER_W = 1;
  localparam int ID_W = 4;

  typedef enum logic [1:0] {
    HEAD,
    FWD,
    DROP
  } egr_state_e;

  function automatic logic dest_is_valid(
    input int dest,
    input int num
  );
    return dest < num;
  endfunction

endpackage

// File: rtl/p4_router_sat_counter.sv
// Saturating event counter with synchronous clear.
// Ports: clk, rst_n, inc, clear (wins over inc), cnt.
module p4_router_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/p4_router_egress_port_demux.sv
// Packet-atomic demux of the egress bus onto per-port AXIS.
// Ports: clk, aresetn, egr_bus_in_*, egr_phys_ports_demuxed_*,
//   port_enable, cnts_clear, drop/stall counters.
module p4_router_egress_port_demux
  import p4_router_egress_pkg::*;
#(
  parameter int NUM_EGR_PHYS_PORTS = 4,
  parameter int EGR_BUS_DATA_BYTES = 4,
  parameter int DEST_WIDTH = DEST_WIDTH_DFLT,
  parameter int DROP_COUNT_WIDTH = 32
) (
  input  logic clk,
  input  logic aresetn,

  input  logic egr_bus_in_tvalid,
  output logic egr_bus_in_tready,
  input  logic [8*EGR_BUS_DATA_BYTES-1:0]
               egr_bus_in_tdata,
  input  logic [EGR_BUS_DATA_BYTES-1:0]
               egr_bus_in_tkeep,
  input  logic [EGR_BUS_DATA_BYTES-1:0]
               egr_bus_in_tstrb,
  input  logic egr_bus_in_tlast,
  input  logic [USER_W-1:0] egr_bus_in_tuser,
  input  logic [DEST_WIDTH-1:0] egr_bus_in_tdest,
  input  logic [ID_W-1:0] egr_bus_in_tid,

  output logic [NUM_EGR_PHYS_PORTS-1:0]
               egr_phys_ports_demuxed_tvalid,
  input  logic [NUM_EGR_PHYS_PORTS-1:0]
               egr_phys_ports_demuxed_tready,
  output logic [NUM_EGR_PHYS_PORTS-1:0]
               [8*EGR_BUS_DATA_BYTES-1:0]
               egr_phys_ports_demuxed_tdata,
  output logic [NUM_EGR_PHYS_PORTS-1:0]
               [EGR_BUS_DATA_BYTES-1:0]
               egr_phys_ports_demuxed_tkeep,
  output logic [NUM_EGR_PHYS_PORTS-1:0]
               [EGR_BUS_DATA_BYTES-1:0]
               egr_phys_ports_demuxed_tstrb,
  output logic [NUM_EGR_PHYS_PORTS-1:0]
               egr_phys_ports_demuxed_tlast,
  output logic [NUM_EGR_PHYS_PORTS-1:0]
               [USER_W-1:0]
               egr_phys_ports_demuxed_tuser,
  output logic [NUM_EGR_PHYS_PORTS-1:0]
               [DEST_WIDTH-1:0]
               egr_phys_ports_demuxed_tdest,
  output logic [NUM_EGR_PHYS_PORTS-1:0]
               [ID_W-1:0]
               egr_phys_ports_demuxed_tid,

  input  logic [NUM_EGR_PHYS_PORTS-1:0] port_enable,
  input  logic cnts_clear,
  output logic [DROP_COUNT_WIDTH-1:0] drop_invalid_cnt,
  output logic [DROP_COUNT_WIDTH-1:0] drop_disabled_cnt,
  output logic [DROP_COUNT_WIDTH-1:0] stall_cnt
);

  localparam int NP = NUM_EGR_PHYS_PORTS;
  localparam int KW = EGR_BUS_DATA_BYTES;
  localparam int DW = 8 * EGR_BUS_DATA_BYTES;

  if (NUM_EGR_PHYS_PORTS <= 0) begin : g_chk_np
    $error("NUM_EGR_PHYS_PORTS must be > 0");
  end
  if (EGR_BUS_DATA_BYTES <= 0) begin : g_chk_db
    $error("EGR_BUS_DATA_BYTES must be > 0");
  end
  if ((2 ** DEST_WIDTH) < NUM_EGR_PHYS_PORTS)
  begin : g_chk_dw
    $error("DEST_WIDTH too narrow for ports");
  end

  // Async assert, sync release of the internal reset.
  logic [1:0] rst_sync_q;
  logic       rst_s;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_s = rst_sync_q[1];

  egr_state_e state_q;
  egr_state_e state_d;
  logic [DEST_WIDTH-1:0] sel_q;
  logic [DEST_WIDTH-1:0] sel_d;
  logic reg_valid_q;
  logic reg_valid_d;
  logic [DW-1:0] data_q;
  logic [DW-1:0] data_d;
  logic [KW-1:0] keep_q;
  logic [KW-1:0] keep_d;
  logic [KW-1:0] strb_q;
  logic [KW-1:0] strb_d;
  logic last_q;
  logic last_d;
  logic [USER_W-1:0] user_q;
  logic [USER_W-1:0] user_d;
  logic [DEST_WIDTH-1:0] dest_q;
  logic [DEST_WIDTH-1:0] dest_d;
  logic [ID_W-1:0] id_q;
  logic [ID_W-1:0] id_d;

  logic sel_ready;
  logic dest_en;
  logic head_ok;
  logic head_drop;
  logic can_load;
  logic load;
  logic in_ready;
  logic inc_inv;
  logic inc_dis;
  logic inc_stall;

  always_comb begin
    sel_ready = 1'b0;
    dest_en = 1'b0;
    for (int i = 0; i < NP; i++) begin
      if (sel_q == DEST_WIDTH'(i)) begin
        sel_ready = egr_phys_ports_demuxed_tready[i];
      end
      if (egr_bus_in_tdest == DEST_WIDTH'(i)) begin
        dest_en = port_enable[i];
      end
    end
  end

  assign head_ok = dest_is_valid(
    int'({1'b0, egr_bus_in_tdest}), NP);
  assign head_drop = !head_ok || !dest_en;
  assign can_load = !reg_valid_q || sel_ready;

  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    in_ready = 1'b0;
    load = 1'b0;
    inc_inv = 1'b0;
    inc_dis = 1'b0;
    unique case (state_q)
      HEAD: begin
        if (egr_bus_in_tvalid && head_drop) begin
          // Drops never touch the register or sel.
          in_ready = 1'b1;
          inc_inv = !head_ok;
          inc_dis = head_ok;
          if (!egr_bus_in_tlast) begin
            state_d = DROP;
          end
        end else begin
          in_ready = can_load;
          if (egr_bus_in_tvalid && can_load) begin
            load = 1'b1;
            sel_d = egr_bus_in_tdest;
            if (!egr_bus_in_tlast) begin
              state_d = FWD;
            end
          end
        end
      end
      FWD: begin
        in_ready = can_load;
        if (egr_bus_in_tvalid && can_load) begin
          load = 1'b1;
          if (egr_bus_in_tlast) begin
            state_d = HEAD;
          end
        end
      end
      DROP: begin
        in_ready = 1'b1;
        if (egr_bus_in_tvalid && egr_bus_in_tlast) begin
          state_d = HEAD;
        end
      end
      default: begin
        state_d = HEAD;
      end
    endcase
  end

  always_comb begin
    reg_valid_d = reg_valid_q;
    data_d = data_q;
    keep_d = keep_q;
    strb_d = strb_q;
    last_d = last_q;
    user_d = user_q;
    dest_d = dest_q;
    id_d = id_q;
    if (load) begin
      reg_valid_d = 1'b1;
      data_d = egr_bus_in_tdata;
      keep_d = egr_bus_in_tkeep;
      strb_d = egr_bus_in_tstrb;
      last_d = egr_bus_in_tlast;
      user_d = egr_bus_in_tuser;
      dest_d = egr_bus_in_tdest;
      id_d = egr_bus_in_tid;
    end else if (sel_ready) begin
      reg_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_s) begin
    if (!rst_s) begin
      state_q <= HEAD;
      sel_q <= '0;
      reg_valid_q <= 1'b0;
      data_q <= '0;
      keep_q <= '0;
      strb_q <= '0;
      last_q <= 1'b0;
      user_q <= '0;
      dest_q <= '0;
      id_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      reg_valid_q <= reg_valid_d;
      data_q <= data_d;
      keep_q <= keep_d;
      strb_q <= strb_d;
      last_q <= last_d;
      user_q <= user_d;
      dest_q <= dest_d;
      id_q <= id_d;
    end
  end

  assign egr_bus_in_tready = in_ready && rst_s;

  always_comb begin
    for (int i = 0; i < NP; i++) begin
      egr_phys_ports_demuxed_tvalid[i] =
        reg_valid_q && (sel_q == DEST_WIDTH'(i));
      egr_phys_ports_demuxed_tdata[i] = data_q;
      egr_phys_ports_demuxed_tkeep[i] = keep_q;
      egr_phys_ports_demuxed_tstrb[i] = strb_q;
      egr_phys_ports_demuxed_tlast[i] = last_q;
      egr_phys_ports_demuxed_tuser[i] = user_q;
      egr_phys_ports_demuxed_tdest[i] = dest_q;
      egr_phys_ports_demuxed_tid[i] = id_q;
    end
  end

  assign inc_stall = reg_valid_q && !sel_ready;

  p4_router_sat_counter #(
    .WIDTH(DROP_COUNT_WIDTH)
  ) u_cnt_inv (
    .clk(clk),
    .rst_n(rst_s),
    .inc(inc_inv),
    .clear(cnts_clear),
    .cnt(drop_invalid_cnt)
  );

  p4_router_sat_counter #(
    .WIDTH(DROP_COUNT_WIDTH)
  ) u_cnt_dis (
    .clk(clk),
    .rst_n(rst_s),
    .inc(inc_dis),
    .clear(cnts_clear),
    .cnt(drop_disabled_cnt)
  );

  p4_router_sat_counter #(
    .WIDTH(DROP_COUNT_WIDTH)
  ) u_cnt_stall (
    .clk(clk),
    .rst_n(rst_s),
    .inc(inc_stall),
    .clear(cnts_clear),
    .cnt(stall_cnt)
  );

endmodule

// File: tb/tb_p4_router_egress_port_demux.sv
// Directed bench for the egress port demux.
// Table of per-cycle vectors plus stall/clear/reset sequences.
module tb_p4_router_egress_port_demux;

  logic clk = 1'b0;
  logic aresetn = 1'b0;

  logic i_v = 1'b0;
  logic i_rdy;
  logic [15:0] i_data = '0;
  logic [1:0] i_keep = 2'b11;
  logic [1:0] i_strb = 2'b11;
  logic i_last = 1'b0;
  logic [0:0] i_user = '0;
  logic [3:0] i_dest = '0;
  logic [3:0] i_id = '0;

  logic [3:0] o_v;
  logic [3:0] o_rdy = 4'hF;
  logic [3:0][15:0] o_data;
  logic [3:0][1:0] o_keep;
  logic [3:0][1:0] o_strb;
  logic [3:0] o_last;
  logic [3:0][0:0] o_user;
  logic [3:0][3:0] o_dest;
  logic [3:0][3:0] o_id;

  logic [3:0] en = 4'hF;
  logic clr = 1'b0;
  logic [7:0] c_inv;
  logic [7:0] c_dis;
  logic [7:0] c_stall;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  p4_router_egress_port_demux #(
    .NUM_EGR_PHYS_PORTS(4),
    .EGR_BUS_DATA_BYTES(2),
    .DEST_WIDTH(4),
    .DROP_COUNT_WIDTH(8)
  ) dut (
    .clk(clk),
    .aresetn(aresetn),
    .egr_bus_in_tvalid(i_v),
    .egr_bus_in_tready(i_rdy),
    .egr_bus_in_tdata(i_data),
    .egr_bus_in_tkeep(i_keep),
    .egr_bus_in_tstrb(i_strb),
    .egr_bus_in_tlast(i_last),
    .egr_bus_in_tuser(i_user),
    .egr_bus_in_tdest(i_dest),
    .egr_bus_in_tid(i_id),
    .egr_phys_ports_demuxed_tvalid(o_v),
    .egr_phys_ports_demuxed_tready(o_rdy),
    .egr_phys_ports_demuxed_tdata(o_data),
    .egr_phys_ports_demuxed_tkeep(o_keep),
    .egr_phys_ports_demuxed_tstrb(o_strb),
    .egr_phys_ports_demuxed_tlast(o_last),
    .egr_phys_ports_demuxed_tuser(o_user),
    .egr_phys_ports_demuxed_tdest(o_dest),
    .egr_phys_ports_demuxed_tid(o_id),
    .port_enable(en),
    .cnts_clear(clr),
    .drop_invalid_cnt(c_inv),
    .drop_disabled_cnt(c_dis),
    .stall_cnt(c_stall)
  );

  typedef struct {
    logic v;
    logic [3:0] d;
    logic [15:0] data;
    logic last;
    logic [3:0] en;
    logic [3:0] rdy;
    logic e_rdy;
    logic [3:0] e_ov;
    logic [15:0] e_data;
    logic e_last;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(
    input string name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  task automatic add(
    input logic v, input logic [3:0] d,
    input logic [15:0] data, input logic last,
    input logic [3:0] e, input logic e_rdy,
    input logic [3:0] e_ov,
    input logic [15:0] e_data, input logic e_last
  );
    vec_t r;
    r.v = v; r.d = d; r.data = data;
    r.last = last; r.en = e; r.rdy = 4'hF;
    r.e_rdy = e_rdy; r.e_ov = e_ov;
    r.e_data = e_data; r.e_last = e_last;
    tbl.push_back(r);
  endtask

  task automatic drive(
    input logic v, input logic [3:0] d,
    input logic [15:0] data, input logic last
  );
    i_v = v; i_dest = d;
    i_data = data; i_last = last;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int idx;
    // 3-beat packet to port 2
    add(1,2,16'hA001,0,4'hF,1,4'b0000,0,0);
    add(1,2,16'hA002,0,4'hF,1,4'b0100,16'hA001,0);
    add(1,2,16'hA003,1,4'hF,1,4'b0100,16'hA002,0);
    // back to back: port 0 (2 beats), port 3
    add(1,0,16'hB001,0,4'hF,1,4'b0100,16'hA003,1);
    add(1,0,16'hB002,1,4'hF,1,4'b0001,16'hB001,0);
    add(1,3,16'hC001,1,4'hF,1,4'b0001,16'hB002,1);
    add(0,0,16'h0000,0,4'hF,1,4'b1000,16'hC001,1);
    add(0,0,16'h0000,0,4'hF,1,4'b0000,0,0);
    // invalid dest 5, 4 beats, then port 1
    add(1,5,16'hD001,0,4'hF,1,4'b0000,0,0);
    add(1,5,16'hD002,0,4'hF,1,4'b0000,0,0);
    add(1,5,16'hD003,0,4'hF,1,4'b0000,0,0);
    add(1,5,16'hD004,1,4'hF,1,4'b0000,0,0);
    add(1,1,16'hE001,1,4'hF,1,4'b0000,0,0);
    add(0,0,16'h0000,0,4'hF,1,4'b0010,16'hE001,1);
    add(0,0,16'h0000,0,4'hF,1,4'b0000,0,0);
    // port 1 disabled at head
    add(1,1,16'hF001,0,4'hD,1,4'b0000,0,0);
    add(1,1,16'hF002,1,4'hD,1,4'b0000,0,0);
    // enabled at head, disabled mid-packet
    add(1,1,16'h9001,0,4'hF,1,4'b0000,0,0);
    add(1,1,16'h9002,1,4'hD,1,4'b0010,16'h9001,0);
    add(0,0,16'h0000,0,4'hD,1,4'b0010,16'h9002,1);
    add(0,0,16'h0000,0,4'hF,1,4'b0000,0,0);

    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ov", 32'(o_v), 0);
    chk("rst_rdy", 32'(i_rdy), 0);
    chk("rst_inv", 32'(c_inv), 0);
    chk("rst_stall", 32'(c_stall), 0);
    @(negedge clk);
    aresetn = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("post_rst_rdy", 32'(i_rdy), 1);

    foreach (tbl[k]) begin
      @(negedge clk);
      drive(tbl[k].v, tbl[k].d,
            tbl[k].data, tbl[k].last);
      en = tbl[k].en;
      o_rdy = tbl[k].rdy;
      #1;
      chk($sformatf("v%0d_rdy", k),
          32'(i_rdy), 32'(tbl[k].e_rdy));
      chk($sformatf("v%0d_ov", k),
          32'(o_v), 32'(tbl[k].e_ov));
      if (tbl[k].e_ov != 0) begin
        idx = 0;
        for (int p = 0; p < 4; p++)
          if (tbl[k].e_ov[p]) idx = p;
        chk($sformatf("v%0d_data", k),
            32'(o_data[idx]), 32'(tbl[k].e_data));
        chk($sformatf("v%0d_last", k),
            32'(o_last[idx]), 32'(tbl[k].e_last));
      end
    end
    @(negedge clk);
    drive(0, 0, 0, 0);
    #1;
    chk("cnt_inv", 32'(c_inv), 1);
    chk("cnt_dis", 32'(c_dis), 1);
    chk("cnt_stall0", 32'(c_stall), 0);

    // stall: port 0 tready low 10 cycles
    @(negedge clk);
    drive(1, 0, 16'h5A5A, 1);
    o_rdy = 4'h0;
    #1;
    chk("st_load_rdy", 32'(i_rdy), 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      drive(0, 0, 0, 0);
      #1;
      chk($sformatf("st%0d_ov", k), 32'(o_v), 1);
      chk($sformatf("st%0d_data", k),
          32'(o_data[0]), 32'h5A5A);
      chk($sformatf("st%0d_rdy", k), 32'(i_rdy), 0);
    end
    @(negedge clk);
    #1;
    chk("stall10", 32'(c_stall), 10);
    o_rdy = 4'hF;
    @(negedge clk);
    #1;
    chk("st_drain_ov", 32'(o_v), 0);
    chk("stall10_hold", 32'(c_stall), 10);

    // clear on a stall cycle wins
    drive(1, 0, 16'h6B6B, 1);
    o_rdy = 4'h0;
    @(negedge clk);
    drive(0, 0, 0, 0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    #1;
    chk("clr_stall", 32'(c_stall), 0);
    chk("clr_inv", 32'(c_inv), 0);
    chk("clr_dis", 32'(c_dis), 0);
    // saturation
    repeat (260) @(negedge clk);
    #1;
    chk("stall_sat", 32'(c_stall), 255);
    o_rdy = 4'hF;
    @(negedge clk);
    #1;
    chk("sat_drain_ov", 32'(o_v), 0);

    // reset mid-packet on beat 2 of 4
    drive(1, 2, 16'h7001, 0);
    @(negedge clk);
    drive(1, 2, 16'h7002, 0);
    @(negedge clk);
    drive(1, 2, 16'h7003, 0);
    #1;
    chk("mr_ov", 32'(o_v), 32'b0100);
    chk("mr_data", 32'(o_data[2]), 32'h7002);
    #1;
    aresetn = 1'b0;
    #1;
    chk("mr_rst_ov", 32'(o_v), 0);
    chk("mr_rst_rdy", 32'(i_rdy), 0);
    chk("mr_rst_stall", 32'(c_stall), 0);
    @(negedge clk);
    aresetn = 1'b1;
    drive(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    drive(1, 3, 16'h8003, 1);
    #1;
    chk("nr_rdy", 32'(i_rdy), 1);
    chk("nr_ov0", 32'(o_v), 0);
    @(negedge clk);
    drive(0, 0, 0, 0);
    #1;
    chk("nr_ov", 32'(o_v), 32'b1000);
    chk("nr_data", 32'(o_data[3]), 32'h8003);
    chk("nr_last", 32'(o_last[3]), 1);
    @(negedge clk);
    #1;
    chk("nr_idle", 32'(o_v), 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
